mem_wb_stage: RTL and testbench

//  MEM stage plus MEM/WB pipeline register. It consumes the EX/MEM buffer outputs and performs data-memory loads and stores.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/data_mem_ram.sv | 18 +
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared opcodes, FSM/access-size encodings and load-extraction helpers for the MEM stage.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

    function automatic size_t decode_size(input logic [5:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? BYTE :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? HALF : WORD;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input size_t sz, input logic uns);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        return sz == BYTE ? {{24{s[7] & ~uns}}, s[7:0]} :
               sz == HALF ? {{16{s[15] & ~uns}}, s[15:0]} : w;
    endfunction

endpackage

// File: rtl/data_mem_ram.sv
// data_mem_ram: DEPTH x 32 data memory with per-byte write enables and asynchronous read.
module data_mem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with multi-cycle loads and the MEM/WB register.
// Optional MEM_WB_STAGE_STATS_EN adds saturating load/store/stall counters.
module mem_wb_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] instruction_in,
    input  logic [31:0] hilowrite_in,
    input  logic [31:0] ReadData2_in,
    input  logic [4:0]  WriteReg_in,
    input  logic        RegWrite_in,
    input  logic        nowrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        stall_in,
    output logic        MemStall_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  WriteReg_out,
    output logic        RegWrite_out,
    output logic        nowrite_out,
    output logic        MemToReg_out,
    output logic        stall_out,
    output logic        AlignErr_out
`ifdef MEM_WB_STAGE_STATS_EN
    ,
    output logic [31:0] LoadCount_out,
    output logic [31:0] StoreCount_out,
    output logic [31:0] StallCycles_out
`endif
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] l_addr;
    size_t       l_size;
    logic        l_uns, l_rw, l_nw;
    logic [4:0]  l_reg;

    logic [5:0]  op;
    size_t       size;
    logic        uns, misal, do_store, do_load, ld_now, done, align_err;
    logic [31:0] rd_addr, rdata, ld_data, wdata;
    logic [3:0]  be;
    logic        unused_bits;

    assign op        = instruction_in[31:26];
    assign size      = decode_size(op);
    assign uns       = op == OP_LBU || op == OP_LHU;
    assign misal     = size == HALF ? hilowrite_in[0] : size == WORD ? |hilowrite_in[1:0] : 1'b0;
    assign do_store  = state == IDLE && MemWrite_in && !stall_in && !misal;
    assign do_load   = state == IDLE && MemRead_in && !MemWrite_in && !stall_in && !misal;
    assign align_err = state == IDLE && (MemRead_in || MemWrite_in) && !stall_in && misal;
    assign ld_now    = do_load && MEM_LATENCY == 1;
    assign done      = state == BUSY && cnt == 3'd1;
    // Stall drops in the completing cycle so upstream advances on the same edge the result lands.
    assign MemStall_out = (state == BUSY && !done) || (do_load && MEM_LATENCY > 1);

    assign rd_addr = state == BUSY ? l_addr : hilowrite_in;
    assign ld_data = done ? load_ext(rdata, rd_addr[1:0], l_size, l_uns)
                          : load_ext(rdata, rd_addr[1:0], size, uns);
    assign wdata   = size == BYTE ? {4{ReadData2_in[7:0]}} :
                     size == HALF ? {2{ReadData2_in[15:0]}} : ReadData2_in;
    assign be      = !do_store ? 4'b0000 :
                     size == BYTE ? 4'b0001 << hilowrite_in[1:0] :
                     size == HALF ? (hilowrite_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign unused_bits = ^{instruction_in[25:0], rd_addr[31:IW+2]};

    data_mem_ram #(.DEPTH(MEM_DEPTH)) u_ram (
        .clk  (Clk),
        .be   (be),
        .waddr(hilowrite_in[IW+1:2]),
        .wdata(wdata),
        .raddr(rd_addr[IW+1:2]),
        .rdata(rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            l_addr        <= '0;
            l_size        <= BYTE;
            l_uns         <= 1'b0;
            l_rw          <= 1'b0;
            l_nw          <= 1'b0;
            l_reg         <= '0;
            ReadData_out  <= '0;
            ALUResult_out <= '0;
            WriteReg_out  <= '0;
            RegWrite_out  <= 1'b0;
            nowrite_out   <= 1'b0;
            MemToReg_out  <= 1'b0;
            stall_out     <= 1'b0;
            AlignErr_out  <= 1'b0;
        end else begin
            AlignErr_out <= align_err;
            if (done || ld_now) begin
                ReadData_out  <= ld_data;
                ALUResult_out <= done ? l_addr : hilowrite_in;
                WriteReg_out  <= done ? l_reg : WriteReg_in;
                RegWrite_out  <= done ? l_rw : RegWrite_in;
                nowrite_out   <= done ? l_nw : nowrite_in;
                MemToReg_out  <= 1'b1;
                stall_out     <= 1'b0;
            end else if (MemStall_out) begin
                RegWrite_out <= 1'b0;
                nowrite_out  <= 1'b0;
                MemToReg_out <= 1'b0;
                stall_out    <= 1'b0;
            end else begin
                ALUResult_out <= hilowrite_in;
                WriteReg_out  <= WriteReg_in;
                nowrite_out   <= nowrite_in;
                RegWrite_out  <= RegWrite_in && !stall_in && !MemWrite_in && !MemRead_in;
                MemToReg_out  <= 1'b0;
                stall_out     <= stall_in;
            end
            if (do_load && MEM_LATENCY > 1) begin
                state  <= BUSY;
                cnt    <= LAT_M1;
                l_addr <= hilowrite_in;
                l_size <= size;
                l_uns  <= uns;
                l_rw   <= RegWrite_in;
                l_nw   <= nowrite_in;
                l_reg  <= WriteReg_in;
            end else if (state == BUSY) begin
                state <= done ? IDLE : BUSY;
                cnt   <= cnt - 3'd1;
            end
        end
    end

`ifdef MEM_WB_STAGE_STATS_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            LoadCount_out   <= '0;
            StoreCount_out  <= '0;
            StallCycles_out <= '0;
        end else begin
            if ((done || ld_now) && LoadCount_out != '1) LoadCount_out <= LoadCount_out + 32'd1;
            if (do_store && StoreCount_out != '1) StoreCount_out <= StoreCount_out + 32'd1;
            if (MemStall_out && StallCycles_out != '1) StallCycles_out <= StallCycles_out + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage (MEM_LATENCY=2, MEM_DEPTH=1024).
module tb_mem_wb_stage;
    import mem_stage_pkg::*;

    logic        Clk = 1'b0, Rst_n = 1'b0;
    logic [31:0] instruction_in, hilowrite_in, ReadData2_in;
    logic [4:0]  WriteReg_in;
    logic        RegWrite_in, nowrite_in, MemWrite_in, MemRead_in, stall_in;
    logic        MemStall_out, RegWrite_out, nowrite_out, MemToReg_out, stall_out, AlignErr_out;
    logic [31:0] ReadData_out, ALUResult_out;
    logic [4:0]  WriteReg_out;
`ifdef MEM_WB_STAGE_STATS_EN
    logic [31:0] LoadCount_out, StoreCount_out, StallCycles_out;
`endif
    int checks = 0, errors = 0;

    always #5 Clk = ~Clk;

    mem_wb_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .instruction_in(instruction_in), .hilowrite_in(hilowrite_in),
        .ReadData2_in(ReadData2_in), .WriteReg_in(WriteReg_in), .RegWrite_in(RegWrite_in),
        .nowrite_in(nowrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .stall_in(stall_in), .MemStall_out(MemStall_out), .ReadData_out(ReadData_out),
        .ALUResult_out(ALUResult_out), .WriteReg_out(WriteReg_out), .RegWrite_out(RegWrite_out),
        .nowrite_out(nowrite_out), .MemToReg_out(MemToReg_out), .stall_out(stall_out),
        .AlignErr_out(AlignErr_out)
`ifdef MEM_WB_STAGE_STATS_EN
        , .LoadCount_out(LoadCount_out), .StoreCount_out(StoreCount_out), .StallCycles_out(StallCycles_out)
`endif
    );

    task automatic set_in(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] wr, input logic rw, input logic mr, input logic mw, input logic st);
        instruction_in = {op, 26'h0};
        hilowrite_in   = a;
        ReadData2_in   = d;
        WriteReg_in    = wr;
        RegWrite_in    = rw;
        nowrite_in     = 1'b0;
        MemRead_in     = mr;
        MemWrite_in    = mw;
        stall_in       = st;
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic nop;
        set_in(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        set_in(op, a, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        nop();
    endtask

    // Issues a load, holds inputs while stalled, and returns what was observed along the way.
    task automatic load(input logic [5:0] op, input logic [31:0] a, input logic [4:0] wr,
                        output logic [31:0] rd, output logic s_issue, output logic s_done,
                        output logic rw_mid, output logic rw, output logic m2r);
        set_in(op, a, 32'h0, wr, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 s_issue = MemStall_out;
        tick();
        s_done = MemStall_out;
        rw_mid = RegWrite_out;
        tick();
        nop();
        rd  = ReadData_out;
        rw  = RegWrite_out;
        m2r = MemToReg_out;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        nop();
        tick();
        tick();
        checks++; if (ReadData_out !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h exp 0", ReadData_out); end
        checks++; if ({RegWrite_out, MemToReg_out, stall_out, AlignErr_out, nowrite_out} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000", {RegWrite_out, MemToReg_out, stall_out, AlignErr_out, nowrite_out}); end
        checks++; if (MemStall_out !== 1'b0) begin errors++; $display("FAIL reset_memstall: got %b exp 0", MemStall_out); end
        checks++; if ({ALUResult_out, WriteReg_out} !== 37'h0) begin errors++; $display("FAIL reset_alu_wreg: got %h/%h exp 0", ALUResult_out, WriteReg_out); end
        Rst_n = 1'b1;
    endtask

    task automatic test_sw_lw;
        logic [31:0] rd;
        logic si, sd, rm, rw, m2r;
        set_in(OP_SW, 32'h10, 32'hAABBCCDD, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (MemStall_out !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b exp 0", MemStall_out); end
        tick();
        checks++; if ({RegWrite_out, MemToReg_out} !== 2'b00) begin errors++; $display("FAIL sw_ctrl: got %b exp 00", {RegWrite_out, MemToReg_out}); end
        nop();
        load(OP_LW, 32'h10, 5'd9, rd, si, sd, rm, rw, m2r);
        checks++; if ({si, sd} !== 2'b10) begin errors++; $display("FAIL lw_stall_profile: got %b exp 10", {si, sd}); end
        checks++; if (rm !== 1'b0) begin errors++; $display("FAIL lw_bubble: got %b exp 0", rm); end
        checks++; if (rd !== 32'hAABBCCDD) begin errors++; $display("FAIL lw_data: got %h exp aabbccdd", rd); end
        checks++; if ({rw, m2r} !== 2'b11) begin errors++; $display("FAIL lw_ctrl: got %b exp 11", {rw, m2r}); end
        checks++; if (WriteReg_out !== 5'd9) begin errors++; $display("FAIL lw_wreg: got %0d exp 9", WriteReg_out); end
    endtask

    task automatic test_extend;
        logic [31:0] rd;
        logic si, sd, rm, rw, m2r;
        load(OP_LB, 32'h11, 5'd1, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'hFFFFFFCC) begin errors++; $display("FAIL lb: got %h exp ffffffcc", rd); end
        load(OP_LBU, 32'h11, 5'd1, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'h000000CC) begin errors++; $display("FAIL lbu: got %h exp 000000cc", rd); end
        load(OP_LH, 32'h12, 5'd1, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'hFFFFAABB) begin errors++; $display("FAIL lh: got %h exp ffffaabb", rd); end
        load(OP_LHU, 32'h12, 5'd1, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'h0000AABB) begin errors++; $display("FAIL lhu: got %h exp 0000aabb", rd); end
    endtask

    task automatic test_sb;
        logic [31:0] rd;
        logic si, sd, rm, rw, m2r;
        store(OP_SB, 32'h13, 32'h00000011);
        load(OP_LW, 32'h10, 5'd2, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'h11BBCCDD) begin errors++; $display("FAIL sb_lane3: got %h exp 11bbccdd", rd); end
    endtask

    task automatic test_stats;
`ifdef MEM_WB_STAGE_STATS_EN
        checks++; if (LoadCount_out !== 32'd6) begin errors++; $display("FAIL load_count: got %0d exp 6", LoadCount_out); end
        checks++; if (StoreCount_out !== 32'd2) begin errors++; $display("FAIL store_count: got %0d exp 2", StoreCount_out); end
        checks++; if (StallCycles_out !== 32'd6) begin errors++; $display("FAIL stall_cycles: got %0d exp 6", StallCycles_out); end
`endif
    endtask

    task automatic test_misalign;
        set_in(OP_LW, 32'h12, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (MemStall_out !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b exp 0", MemStall_out); end
        tick();
        nop();
        checks++; if ({AlignErr_out, RegWrite_out} !== 2'b10) begin errors++; $display("FAIL misalign_err: got %b exp 10", {AlignErr_out, RegWrite_out}); end
        tick();
        checks++; if (AlignErr_out !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b exp 0", AlignErr_out); end
        store(OP_SH, 32'h11, 32'h0000FFFF);
        checks++; if (AlignErr_out !== 1'b1) begin errors++; $display("FAIL sh_misalign: got %b exp 1", AlignErr_out); end
    endtask

    task automatic test_stall_in;
        logic [31:0] rd;
        logic si, sd, rm, rw, m2r;
        set_in(OP_SW, 32'h10, 32'hDEADBEEF, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        nop();
        checks++; if ({stall_out, RegWrite_out} !== 2'b10) begin errors++; $display("FAIL stall_in_ctrl: got %b exp 10", {stall_out, RegWrite_out}); end
        load(OP_LW, 32'h10, 5'd2, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'h11BBCCDD) begin errors++; $display("FAIL stall_in_mem: got %h exp 11bbccdd", rd); end
    endtask

    task automatic test_passthrough;
        set_in(6'h00, 32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        checks++; if ({RegWrite_out, MemToReg_out, stall_out} !== 3'b100) begin errors++; $display("FAIL pass_ctrl: got %b exp 100", {RegWrite_out, MemToReg_out, stall_out}); end
        checks++; if ({ALUResult_out, WriteReg_out} !== {32'h55, 5'd7}) begin errors++; $display("FAIL pass_data: got %h/%0d exp 55/7", ALUResult_out, WriteReg_out); end
    endtask

    task automatic test_wrap_and_sh;
        logic [31:0] rd;
        logic si, sd, rm, rw, m2r;
        store(OP_SW, 32'h1010, 32'h12345678);
        load(OP_LW, 32'h10, 5'd2, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap: got %h exp 12345678", rd); end
        store(OP_SW, 32'h14, 32'h0);
        store(OP_SH, 32'h16, 32'h1234BEEF);
        load(OP_LW, 32'h14, 5'd2, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL sh_upper: got %h exp beef0000", rd); end
    endtask

    task automatic test_read_write;
        logic [31:0] rd;
        logic si, sd, rm, rw, m2r;
        set_in(OP_SW, 32'h20, 32'hCAFEF00D, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (MemStall_out !== 1'b0) begin errors++; $display("FAIL rw_both_stall: got %b exp 0", MemStall_out); end
        tick();
        nop();
        checks++; if (RegWrite_out !== 1'b0) begin errors++; $display("FAIL rw_both_regwrite: got %b exp 0", RegWrite_out); end
        load(OP_LW, 32'h20, 5'd2, rd, si, sd, rm, rw, m2r);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_both_store: got %h exp cafef00d", rd); end
    endtask

    task automatic test_reset_busy;
        set_in(OP_LW, 32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        Rst_n = 1'b0;
        tick();
        nop();
        #1;
        checks++; if ({ReadData_out, RegWrite_out, MemToReg_out, MemStall_out} !== 35'h0) begin errors++; $display("FAIL reset_busy: got %h %b%b%b exp 0", ReadData_out, RegWrite_out, MemToReg_out, MemStall_out); end
        Rst_n = 1'b1;
        tick();
        checks++; if ({ReadData_out, RegWrite_out, MemToReg_out} !== 34'h0) begin errors++; $display("FAIL reset_no_wb: got %h %b%b exp 0", ReadData_out, RegWrite_out, MemToReg_out); end
    endtask

    initial begin
        nop();
        test_reset();
        test_sw_lw();
        test_extend();
        test_sb();
        test_stats();
        test_misalign();
        test_stall_in();
        test_passthrough();
        test_wrap_and_sh();
        test_read_write();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
